// File: rtl/dstrb_pkg.sv
// Shared types and default constants for the data-rate strobe generator.
// The optional data_stb output is controlled by the DATA_STB_EN macro in the top.
package dstrb_pkg;

  localparam int CNT_W       = 8;
  localparam int DIV_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

endpackage

// File: rtl/data_strobe_gen_if.sv
// Divider-load handshake between a controller (master) and data_strobe_gen (slave).
interface data_strobe_gen_if #(
  parameter int CNT_W = dstrb_pkg::CNT_W
);

  logic [CNT_W-1:0] div_half;
  logic             div_load;
  logic             div_ack;
  logic             div_err;

  modport master (output div_half, output div_load, input div_ack, input div_err);
  modport slave  (input div_half, input div_load, output div_ack, output div_err);

endinterface

// File: rtl/strobe_half_cnt.sv
// Half-period counter: counts up to cmp and then holds there until it is cleared.
// tc flags the last cycle of the current half-period.
module strobe_half_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [CNT_W-1:0] cmp,
  output logic             tc
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tc = (cnt_q == cmp);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (!tc) begin
      cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/data_strobe_gen.sv
// Programmable square-wave strobe generator with glitch-free run-time divider update.
// Define DATA_STB_EN to add the data_stb output (pulse on every clk_data rising edge).
module data_strobe_gen #(
  parameter int CNT_W       = dstrb_pkg::CNT_W,
  parameter int DIV_DEFAULT = dstrb_pkg::DIV_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  data_strobe_gen_if.slave   div_if,
  output logic               busy,
  output logic               clk_data
`ifdef DATA_STB_EN
  , output logic             data_stb
`endif
);

  import dstrb_pkg::*;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] div_cur_q, div_cur_d;
  logic [CNT_W-1:0] div_pend_q, div_pend_d;
  logic             pend_q, pend_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic             clk_data_q, clk_data_d;
  logic             cnt_clr;
  logic             tc;
  logic             apply;

  strobe_half_cnt #(.CNT_W(CNT_W)) u_half_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .cmp   (div_cur_q - ONE),
    .tc    (tc)
  );

  // A stop request is only honoured at the end of LOW, so the last pulse is whole.
  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        if (en) state_d = HIGH;
      end
      HIGH: begin
        if (tc) begin
          cnt_clr = 1'b1;
          state_d = LOW;
        end
      end
      LOW: begin
        if (tc) begin
          cnt_clr = 1'b1;
          state_d = en ? HIGH : IDLE;
        end
      end
      default: begin
        cnt_clr = 1'b1;
        state_d = IDLE;
      end
    endcase
    clk_data_d = (state_d == HIGH);
  end

  // Apply happens before the load so a coincident load stays pending for the next period.
  always_comb begin
    div_cur_d  = div_cur_q;
    div_pend_d = div_pend_q;
    pend_d     = pend_q;
    ack_d      = 1'b0;
    err_d      = err_q;
    apply      = pend_q && ((state_q == IDLE) || ((state_q == LOW) && (state_d == HIGH)));
    if (apply) begin
      div_cur_d = div_pend_q;
      pend_d    = 1'b0;
    end
    if (div_if.div_load) begin
      if (div_if.div_half != '0) begin
        div_pend_d = div_if.div_half;
        pend_d     = 1'b1;
        ack_d      = 1'b1;
        err_d      = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      div_cur_q  <= CNT_W'(DIV_DEFAULT);
      div_pend_q <= '0;
      pend_q     <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      clk_data_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cur_q  <= div_cur_d;
      div_pend_q <= div_pend_d;
      pend_q     <= pend_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      clk_data_q <= clk_data_d;
    end
  end

`ifdef DATA_STB_EN
  logic data_stb_q, data_stb_d;

  assign data_stb_d = (state_d == HIGH) && (state_q != HIGH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_stb_q <= 1'b0;
    end else begin
      data_stb_q <= data_stb_d;
    end
  end

  assign data_stb = data_stb_q;
`endif

  assign busy           = (state_q != IDLE);
  assign clk_data       = clk_data_q;
  assign div_if.div_ack = ack_q;
  assign div_if.div_err = err_q;

endmodule

// File: doc/data_strobe_gen.md
# data_strobe_gen

Programmable data-rate strobe generator for the OFDM PHY. Divides the fabric clock `clk` down to the square-wave `clk_data` that paces symbol/sample transfers. It sits directly upstream of the data-strobe edge-extension stage, which consumes `clk_data`. The divide ratio can be changed at run time without glitches, and start/stop is always on whole-period boundaries.

## Interface
- `CNT_W`, 8: half-period counter width; maximum half-period is 2^CNT_W−1 cycles.
- `DIV_DEFAULT`, 32: half-period (in `clk` cycles) loaded at reset; must be 1..2^CNT_W−1.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: run request; level-sensitive.
- `div_half` in CNT_W: requested half-period N; valid range 1..2^CNT_W−1.
- `div_load` in 1: one-cycle request to load `div_half`.
- `div_ack` out 1: one-cycle pulse, the cycle after an accepted load.
- `div_err` out 1: sticky flag; set by a load with `div_half`=0.
- `busy` out 1: high in every state except IDLE.
- `clk_data` out 1: generated strobe; registered output.
- `data_stb` out 1: only with `DATA_STB_EN`; single-cycle pulse coincident with each `clk_data` 0→1 transition.

## Operation
- FSM states: IDLE, HIGH, LOW.
  - IDLE → HIGH when `en`=1.
  - HIGH → LOW after `div_cur` cycles.
  - LOW → HIGH after `div_cur` cycles if `en`=1; otherwise LOW → IDLE.
- `clk_data` is 1 only in HIGH.
- `en` falling during HIGH or LOW does not truncate the period. The current HIGH/LOW pair completes, so the last pulse is full width and `clk_data` ends low.
- Half-period counter:
  - Runs 0..`div_cur`−1 and clears on each phase change.
  - Compare uses `div_cur`−1, so N=1 gives `clk`/2.
  - No wrap beyond the compare value.
- Divider update:
  - A load with `div_half`≠0 is written to `div_pend`, sets the pending flag, and pulses `div_ack` on the next cycle.
  - A load with `div_half`=0 is rejected: no ack, `div_pend` is unchanged, and `div_err` is set.
- `div_err` clears on reset or on the next accepted load.
- Pending value applies as follows:
  - In IDLE it is copied to `div_cur` on the next cycle.
  - While running, it is copied only on the LOW→HIGH or IDLE→HIGH transition, never mid-period.
- Back-to-back loads before application: the last accepted value wins. Each accepted load gets its own `div_ack`.
- A load in the same cycle as the LOW→HIGH transition: the previously pending value applies, and the new value stays pending.

## Timing
- Reset values: `clk_data`=0, `busy`=0, `div_ack`=0, `div_err`=0, `data_stb`=0. Internally, `div_cur`=DIV_DEFAULT, pending=0, state IDLE.
- Start latency: `en` sampled high at edge t gives `clk_data`=1 and `busy`=1 from edge t+1.
- Steady state: exactly N cycles high, then N cycles low, for a period of 2N.
- Stop: `busy` drops on the same edge `clk_data` would have risen again.
- `div_ack` latency: 1 cycle after `div_load`.
- `rst_n` asserted mid-operation forces all outputs to their reset values immediately (asynchronously). After release, the block restarts from IDLE.

## Configuration
- `DATA_STB_EN` defined: the `data_stb` port and its register exist; it is high for exactly the first HIGH cycle of every period.
- `DATA_STB_EN` undefined: the port and logic are absent; all other behaviour is identical.

## Structure
- Shared package `dstrb_pkg` holds:
  - the state enum (IDLE/HIGH/LOW);
  - default constants `CNT_W`=8 and `DIV_DEFAULT`=32.
- One natural sub-module, `strobe_half_cnt`: the half-period counter with synchronous clear, terminal-count flag and a CNT_W-wide compare value. The FSM and divider registers stay in the top level.

## Test plan
- Reset, then `en`=1 with default N=32: `clk_data` rises 1 cycle later; period is 64 cycles with a 32/32 split; `busy`=1.
- Load N=5 mid-HIGH: `div_ack` pulses the next cycle. The current period finishes at 32/32, and the following period is 5/5.
- Load N=0: no `div_ack`; `div_err`=1 and stays 1. A subsequent load of N=3 clears `div_err` and acks.
- `en`→0 two cycles into HIGH with N=4: `clk_data` completes 4 high and 4 low cycles, then IDLE; `busy`=0; no further edges.
- N=1: `clk_data` toggles every cycle. With `DATA_STB_EN` defined, `data_stb` is high every second cycle, aligned with `clk_data` rising.
- `rst_n` pulsed low mid-HIGH: `clk_data` is 0 immediately. `div_cur` returns to 32, and the next `en` gives a 64-cycle period.
